atomrvcore_fetch_ctrl: RTL and testbench

ATOMRVCORE_FETCH_CTRL -- requirements
Module: atomRVCORE_fetch_ctrl

---
 rtl/atomrvcore_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_atomrvcore_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomrvcore_fetch_ctrl.sv
// Instruction fetch controller: issues one outstanding imem request at a time,
// buffers responses with their PC for decode, and drops responses killed by redirects.
module atomrvcore_fetch_ctrl #(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATAWIDTH-1:0] fetch_pc_i,
    input  logic                 branch_i,
    input  logic [DATAWIDTH-1:0] branch_target_i,
    output logic                 ifu_be_o,
    output logic [DATAWIDTH-1:0] ifu_pc_o,
    output logic                 ifu_stall_o,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    output logic                 instr_valid_o,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [DATAWIDTH-1:0] instr_pc_o,
    input  logic                 instr_ready_i,
    output logic [7:0]           drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e               state_q, state_d;
    logic                 discard_q, discard_d;
    logic [DATAWIDTH-1:0] req_pc_q, req_pc_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATAWIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
    logic [DATAWIDTH-1:0] data_mem_q [FIFO_DEPTH];

    logic                 push, pop, drop;
    logic [CNT_W-1:0]     occ_after;

    // A redirect hides the head from decode and kills any response arriving with it.
    always_comb begin
        instr_valid_o = (cnt_q != '0) && !branch_i;
        pop           = instr_valid_o && instr_ready_i;
        push          = 1'b0;
        drop          = 1'b0;
        if (state_q == WAIT && imem_rvalid_i) begin
            if (discard_q || branch_i) drop = 1'b1;
            else                       push = 1'b1;
        end
        occ_after = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        req_pc_d   = req_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt_i) begin
                    req_pc_d  = fetch_pc_i;
                    discard_d = branch_i;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    discard_d = 1'b0;
                    if (drop || occ_after < CNT_W'(FIFO_DEPTH)) state_d = REQ;
                    else                                        state_d = HOLD;
                end else if (branch_i) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (branch_i || occ_after < CNT_W'(FIFO_DEPTH)) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            discard_q  <= 1'b0;
            req_pc_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            req_pc_q   <= req_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Buffer pointers; a redirect empties the buffer at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (branch_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= occ_after;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            data_mem_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    always_comb begin
        ifu_be_o    = branch_i;
        ifu_pc_o    = branch_i ? branch_target_i : '0;
        imem_req_o  = (state_q == REQ);
        imem_addr_o = imem_req_o ? fetch_pc_i : '0;
        ifu_stall_o = !(imem_req_o && imem_gnt_i);
        instr_o     = data_mem_q[rd_ptr_q];
        instr_pc_o  = pc_mem_q[rd_ptr_q];
        drop_cnt_o  = drop_cnt_q;
    end

endmodule

// File: tb/tb_atomrvcore_fetch_ctrl.sv
// Scoreboard bench for atomrvcore_fetch_ctrl: models the IFU PC and an imem responder,
// predicts buffered instructions and drop counts, and compares every cycle.
module tb_atomrvcore_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] fetch_pc_i, branch_target_i, imem_rdata_i;
    logic        branch_i, imem_gnt_i, imem_rvalid_i, instr_ready_i;
    logic        ifu_be_o, ifu_stall_o, imem_req_o, instr_valid_o;
    logic [31:0] ifu_pc_o, imem_addr_o, instr_o, instr_pc_o;
    logic [7:0]  drop_cnt_o;

    atomrvcore_fetch_ctrl #(.DATAWIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_pc_i(fetch_pc_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .ifu_be_o(ifu_be_o), .ifu_pc_o(ifu_pc_o),
        .ifu_stall_o(ifu_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      sb_q[$];
    logic [31:0] pop_pcs[$];
    logic [31:0] gnt_addrs[$];
    int          errors = 0;
    int          checks = 0;

    logic [31:0] pc_model;
    bit          pend, pend_disc;
    int          pend_cnt;
    logic [31:0] pend_pc;
    int          lat = 1;
    bit          lat_rand = 1'b0;
    int          drop_exp, drop_total;
    bit          gnt_en, ready_en, br_on_rsp, stray;
    bit          last_req, last_stall, last_valid;
    int          idx;
    int          d0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] pc);
        return (pc << 1) ^ 32'hDEAD_BEEF;
    endfunction

    // One clock: drive at +1, check at +5, advance the model at the edge.
    task automatic cycle(input bit br_in, input logic [31:0] tgt);
        bit          rv, br, g, exp_valid, pop_now;
        int          occ;
        entry_t      e;
        logic [31:0] obs_pc;
        rv = pend && (pend_cnt == 0);
        br = br_in || (br_on_rsp && rv);
        fetch_pc_i      = pc_model;
        branch_i        = br;
        branch_target_i = tgt;
        imem_gnt_i      = gnt_en;
        imem_rvalid_i   = rv || stray;
        imem_rdata_i    = rv ? rdata_of(pend_pc) : 32'hBAD0_0000;
        instr_ready_i   = ready_en;
        #4;
        g         = imem_req_o && gnt_en;
        exp_valid = (sb_q.size() != 0) && !br;
        check_eq("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
        if (exp_valid && instr_valid_o) begin
            e = sb_q[0];
            check_eq("instr_pc", instr_pc_o, e.pc);
            check_eq("instr_data", instr_o, e.data);
        end
        pop_now = exp_valid && ready_en;
        check_eq("ifu_be", 32'(ifu_be_o), 32'(br));
        check_eq("ifu_pc", ifu_pc_o, br ? tgt : 32'h0);
        check_eq("ifu_stall", 32'(ifu_stall_o), 32'(!g));
        check_eq("drop_cnt", 32'(drop_cnt_o), 32'(drop_exp));
        if (imem_req_o) check_eq("imem_addr", imem_addr_o, pc_model);
        if (g) begin
            occ = sb_q.size() - (pop_now ? 1 : 0);
            check_eq("one_outstanding", 32'(pend), 32'd0);
            check_eq("req_room", 32'(occ < DEPTH), 32'd1);
            gnt_addrs.push_back(imem_addr_o);
        end
        last_req   = imem_req_o;
        last_stall = ifu_stall_o;
        last_valid = instr_valid_o;
        obs_pc     = instr_pc_o;
        @(posedge clk_i);
        if (pop_now) begin
            pop_pcs.push_back(obs_pc);
            void'(sb_q.pop_front());
        end
        if (rv) begin
            pend = 1'b0;
            if (pend_disc || br) begin
                drop_total++;
                if (drop_exp < 255) drop_exp++;
            end else begin
                e.pc   = pend_pc;
                e.data = rdata_of(pend_pc);
                sb_q.push_back(e);
            end
        end else if (pend) begin
            pend_cnt--;
            if (br) pend_disc = 1'b1;
        end
        if (br) sb_q.delete();
        if (g) begin
            pend      = 1'b1;
            pend_pc   = pc_model;
            pend_cnt  = lat_rand ? int'($urandom_range(2, 0)) : lat - 1;
            pend_disc = br;
        end
        if (br)     pc_model = tgt;
        else if (g) pc_model = pc_model + 32'd4;
        #1;
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        branch_i      = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) begin
            #4;
            check_eq("rst_req", 32'(imem_req_o), 32'd0);
            check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
            check_eq("rst_be", 32'(ifu_be_o), 32'd0);
            check_eq("rst_stall", 32'(ifu_stall_o), 32'd1);
            check_eq("rst_drop", 32'(drop_cnt_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
        sb_q.delete();
        pend       = 1'b0;
        pend_disc  = 1'b0;
        drop_exp   = 0;
        drop_total = 0;
        pc_model   = 32'h0;
    endtask

    task automatic wait_pend(input bit want_rsp_now, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pend && ((pend_cnt == 0) == want_rsp_now)) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 32'h0);
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; fetch_pc_i = '0; branch_i = 1'b0; branch_target_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
        gnt_en = 1'b1; ready_en = 1'b1; br_on_rsp = 1'b0; stray = 1'b0;
        @(posedge clk_i);
        #1;
        do_reset();

        // In-order fetch from PC 0 with single-cycle responses
        repeat (12) cycle(1'b0, 32'h0);
        check_eq("p1_pops", 32'(pop_pcs.size() >= 3), 32'd1);
        if (pop_pcs.size() >= 3) begin
            check_eq("p1_pc0", pop_pcs[0], 32'h0);
            check_eq("p1_pc1", pop_pcs[1], 32'h4);
            check_eq("p1_pc2", pop_pcs[2], 32'h8);
        end

        // Decode backpressure fills the buffer and parks the FSM
        ready_en = 1'b0;
        repeat (10) cycle(1'b0, 32'h0);
        check_eq("hold_req", 32'(last_req), 32'd0);
        check_eq("hold_stall", 32'(last_stall), 32'd1);
        check_eq("hold_valid", 32'(last_valid), 32'd1);
        ready_en = 1'b1;
        cycle(1'b0, 32'h0);
        ready_en = 1'b0;
        cycle(1'b0, 32'h0);
        check_eq("hold_resume", 32'(last_req), 32'd1);

        // Redirect while waiting on a slow response
        ready_en = 1'b1;
        lat = 3;
        wait_pend(1'b0, "wait_before_branch");
        d0  = drop_exp;
        idx = gnt_addrs.size();
        cycle(1'b1, 32'h100);
        cycle(1'b0, 32'h0);
        check_eq("br_flush", 32'(last_valid), 32'd0);
        repeat (6) cycle(1'b0, 32'h0);
        check_eq("br_drop", 32'(drop_cnt_o), 32'(d0 + 1));
        check_eq("br_gnt_seen", 32'(gnt_addrs.size() > idx), 32'd1);
        if (gnt_addrs.size() > idx) check_eq("br_next_addr", gnt_addrs[idx], 32'h100);

        // Redirect coincident with the response
        lat = 2;
        wait_pend(1'b1, "wait_rsp_branch");
        d0 = drop_exp;
        cycle(1'b1, 32'h180);
        cycle(1'b0, 32'h0);
        check_eq("brrv_valid", 32'(last_valid), 32'd0);
        check_eq("brrv_drop", 32'(drop_cnt_o), 32'(d0 + 1));

        // Reset while a response is outstanding; the late response must be ignored
        lat = 5;
        wait_pend(1'b0, "wait_before_reset");
        do_reset();
        pc_model = 32'h40;
        idx = gnt_addrs.size();
        stray = 1'b1;
        cycle(1'b0, 32'h0);
        stray = 1'b0;
        lat = 1;
        repeat (4) cycle(1'b0, 32'h0);
        check_eq("rst_late_drop", 32'(drop_cnt_o), 32'd0);
        check_eq("rst_gnt_seen", 32'(gnt_addrs.size() > idx), 32'd1);
        if (gnt_addrs.size() > idx) check_eq("rst_first_addr", gnt_addrs[idx], 32'h40);

        // Drop counter saturation
        br_on_rsp = 1'b1;
        for (int i = 0; i < 1500 && drop_total < 300; i++) cycle(1'b0, 32'h300);
        br_on_rsp = 1'b0;
        check_eq("sat_reached", 32'(drop_total >= 300), 32'd1);
        check_eq("sat_value", 32'(drop_cnt_o), 32'd255);

        // Random grants, latencies, backpressure and redirects
        lat_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            gnt_en   = ($urandom_range(3, 0) != 0);
            ready_en = ($urandom_range(2, 0) != 0);
            cycle(($urandom_range(19, 0) == 0), {$urandom_range(255, 0), 2'b00} + 32'h1000);
        end
        lat_rand = 1'b0;
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        idx = pop_pcs.size();
        repeat (12) cycle(1'b0, 32'h0);
        check_eq("drain_progress", 32'(pop_pcs.size() > idx), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
